// File: rtl/nes_joypad_emu.sv
// NES controller emulator: debounced board buttons presented as a 4021-style serial shift register.
// Optional turbo A/B support is compiled in with `define NES_JOYPAD_TURBO_EN.
module nes_joypad_emu #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned TURBO_HALF_CYCLES = 3333333
) (
  input  logic       CLK_100MHZ,
  input  logic       nRESET,
  input  logic [7:0] BTN_n,
`ifdef NES_JOYPAD_TURBO_EN
  input  logic [1:0] TURBO,
`endif
  input  logic       NES_JOYPAD_CLK,
  input  logic       NES_JOYPAD_LATCH,
  output logic       NES_JOYPAD_DATA,
  output logic [7:0] BTN_STATE
);

  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbMax = DbW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StEmpty = 2'd3;

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge CLK_100MHZ or negedge nRESET) begin
    if (!nRESET) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Synchronisers run on the raw reset so they are already settled when the core is released.
  logic [7:0] btn_s1_q, btn_s2_q;
  logic [2:0] jclk_q;
  logic [1:0] latch_q;

  always_ff @(posedge CLK_100MHZ or negedge nRESET) begin
    if (!nRESET) begin
      btn_s1_q <= 8'h00;
      btn_s2_q <= 8'h00;
      jclk_q   <= 3'b000;
      latch_q  <= 2'b00;
    end else begin
      btn_s1_q <= ~BTN_n;
      btn_s2_q <= btn_s1_q;
      jclk_q   <= {jclk_q[1:0], NES_JOYPAD_CLK};
      latch_q  <= {latch_q[0], NES_JOYPAD_LATCH};
    end
  end

  logic latch_sync, clk_rise;
  assign latch_sync = latch_q[1];
  assign clk_rise   = jclk_q[1] & ~jclk_q[2];

  logic [7:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [7:0]          btn_state_q, btn_state_d;

  always_comb begin
    db_cnt_d    = db_cnt_q;
    btn_state_d = btn_state_q;
    for (int i = 0; i < 8; i++) begin
      if (btn_s2_q[i] == btn_state_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbMax) begin
        btn_state_d[i] = btn_s2_q[i];
        db_cnt_d[i]    = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q    <= '0;
      btn_state_q <= 8'h00;
    end else begin
      db_cnt_q    <= db_cnt_d;
      btn_state_q <= btn_state_d;
    end
  end

  logic [7:0] report;

`ifdef NES_JOYPAD_TURBO_EN
  localparam int unsigned TbW = (TURBO_HALF_CYCLES > 1) ? $clog2(TURBO_HALF_CYCLES) : 1;
  localparam logic [TbW-1:0] TbMax = TbW'(TURBO_HALF_CYCLES - 1);

  logic [TbW-1:0] turbo_cnt_q;
  logic           phase_q;

  always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      turbo_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (turbo_cnt_q == TbMax) begin
      turbo_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      turbo_cnt_q <= turbo_cnt_q + 1'b1;
    end
  end

  assign report = {btn_state_q[7:2],
                   btn_state_q[1] & (~TURBO[1] | phase_q),
                   btn_state_q[0] & (~TURBO[0] | phase_q)};
`else
  assign report = btn_state_q;
`endif

  logic [1:0] state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       data_q;

  // Latch has priority over a coincident clock edge; Idle ignores clocks until the first load.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    if (latch_sync) begin
      state_d   = StLoad;
      sr_d      = report;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        StLoad, StShift: begin
          if (clk_rise) begin
            sr_d      = {1'b1, sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = (bit_cnt_q == 4'd7) ? StEmpty : StShift;
          end else if (state_q == StLoad) begin
            state_d = StShift;
          end
        end
        StEmpty: begin
          if (clk_rise) sr_d = {1'b1, sr_q[7:1]};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sr_q      <= 8'h00;
      bit_cnt_q <= 4'd0;
      data_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= ~sr_q[0];
    end
  end

  assign NES_JOYPAD_DATA = data_q;
  assign BTN_STATE       = btn_state_q;

endmodule

// File: tb/tb_nes_joypad_emu.sv
// Scoreboard bench for nes_joypad_emu: directed stimulus queues expectations, a monitor checks them.
module tb_nes_joypad_emu;

  localparam int unsigned Db = 16;
  localparam int unsigned Th = 8;

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] btn_n;
  logic       jclk;
  logic       latch;
  logic       data;
  logic [7:0] btn_state;
`ifdef NES_JOYPAD_TURBO_EN
  logic [1:0] turbo;
`endif

  always #5 clk = ~clk;

  nes_joypad_emu #(
    .DEBOUNCE_CYCLES  (Db),
    .TURBO_HALF_CYCLES(Th)
  ) dut (
    .CLK_100MHZ      (clk),
    .nRESET          (nreset),
    .BTN_n           (btn_n),
`ifdef NES_JOYPAD_TURBO_EN
    .TURBO           (turbo),
`endif
    .NES_JOYPAD_CLK  (jclk),
    .NES_JOYPAD_LATCH(latch),
    .NES_JOYPAD_DATA (data),
    .BTN_STATE       (btn_state)
  );

  // sel: 0 = serial data, 1 = BTN_STATE, 2 = bench-measured value in tb_act
  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
    logic [7:0] tb_act;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int unsigned push_cnt = 0;
  int unsigned pop_cnt  = 0;
  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string name, input int sel, input logic [7:0] exp,
                            input logic [7:0] tb_act = 8'h00);
    sb_item_t it;
    it.name   = name;
    it.sel    = sel;
    it.exp    = exp;
    it.tb_act = tb_act;
    sb_q.push_back(it);
    push_cnt++;
  endtask

  task automatic jclk_pulse();
    jclk = 1'b1;
    tick(2);
    jclk = 1'b0;
    tick(4);
  endtask

  task automatic latch_pulse();
    latch = 1'b1;
    tick(2);
    latch = 1'b0;
    tick(2);
  endtask

  // Monitor: compares the DUT output in the same timestep the expectation is presented.
  initial begin
    sb_item_t   it;
    logic [7:0] act;
    forever begin
      wait (push_cnt != pop_cnt);
      it = sb_q.pop_front();
      pop_cnt++;
      case (it.sel)
        0:       act = {7'b0, data};
        1:       act = btn_state;
        default: act = it.tb_act;
      endcase
      checks++;
      if (act !== it.exp) begin
        failures++;
        $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.exp, $time);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seq;
    nreset = 1'b0;
    btn_n  = 8'h00;
    jclk   = 1'b0;
    latch  = 1'b0;
`ifdef NES_JOYPAD_TURBO_EN
    turbo  = 2'b00;
`endif
    tick(3);
    expect_val("reset_data", 0, 8'h01);
    expect_val("reset_btn", 1, 8'h00);

    // All buttons held through reset: accepted D+2 clocks after release.
    nreset = 1'b1;
    tick(Db + 1);
    expect_val("rel_btn_early", 1, 8'h00);
    tick(2);
    expect_val("rel_btn_ff", 1, 8'hFF);
    expect_val("rel_data_idle", 0, 8'h01);

    btn_n = 8'hFF;
    tick(20);
    expect_val("release_all", 1, 8'h00);

    // Short glitch on A must be filtered.
    btn_n = 8'hFE;
    tick(10);
    btn_n = 8'hFF;
    tick(25);
    expect_val("glitch_filtered", 1, 8'h00);

    // Held A: 2 sync + 16 stable clocks.
    btn_n = 8'hFE;
    tick(17);
    expect_val("db_edge17", 1, 8'h00);
    tick(1);
    expect_val("db_edge18", 1, 8'h01);

    btn_n = 8'hF6;
    tick(20);
    expect_val("a_start", 1, 8'h09);

    // Read sequence with A+START pressed.
    seq = 8'hF6;
    latch_pulse();
    for (int i = 0; i < 8; i++) begin
      expect_val($sformatf("read_bit%0d", i), 0, {7'b0, seq[i]});
      jclk_pulse();
    end
    expect_val("after_8th", 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      jclk_pulse();
      expect_val($sformatf("overrun%0d", i), 0, 8'h00);
    end

    // Release A mid-read: shift register must not change until the next latch.
    btn_n = 8'hF7;
    tick(20);
    expect_val("start_only", 1, 8'h08);
    expect_val("sr_frozen", 0, 8'h00);
    latch_pulse();
    expect_val("reload_a_rel", 0, 8'h01);
    jclk_pulse();
    expect_val("reload_b", 0, 8'h01);
    jclk_pulse();
    expect_val("reload_sel", 0, 8'h01);

    // Latch and clock rising together: load must win.
    latch = 1'b1;
    jclk  = 1'b1;
    tick(1);
    latch = 1'b0;
    tick(3);
    expect_val("collision_a", 0, 8'h01);
    jclk = 1'b0;
    tick(2);
    jclk_pulse();
    expect_val("coll_b", 0, 8'h01);
    jclk_pulse();
    expect_val("coll_sel", 0, 8'h01);
    jclk_pulse();
    expect_val("coll_start", 0, 8'h00);

    // Reset mid-shift.
    #2;
    nreset = 1'b0;
    #1;
    expect_val("midrst_data", 0, 8'h01);
    expect_val("midrst_btn", 1, 8'h00);
    tick(2);
    nreset = 1'b1;
    tick(3);
    jclk_pulse();
    expect_val("post_rst_idle", 0, 8'h01);

`ifdef NES_JOYPAD_TURBO_EN
    begin
      int zeros;
      btn_n = 8'hFE;
      tick(22);
      turbo = 2'b01;
      latch = 1'b1;
      tick(6);
      zeros = 0;
      for (int i = 0; i < 32; i++) begin
        tick(1);
        if (data == 1'b0) zeros++;
      end
      expect_val("turbo_duty", 2, 8'd16, 8'(zeros));
      turbo = 2'b00;
      tick(6);
      zeros = 0;
      for (int i = 0; i < 16; i++) begin
        tick(1);
        if (data == 1'b0) zeros++;
      end
      expect_val("turbo_off", 2, 8'd16, 8'(zeros));
      latch = 1'b0;
    end
`endif

    tick(2);
    if (push_cnt != pop_cnt) begin
      failures++;
      $display("FAIL drain: %0d expectations unchecked, expected 0", push_cnt - pop_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
